fifo_rd_ctrl: RTL and testbench

Read-side controller for the team's synchronous FIFO (registered data_out, one-cycle read latency, registered empty flag). It pops words whenever the FIFO holds data and there is room downstream. Popped words pass through a 2-entry skid buffer and are presented on a valid/ready stream. The block sits between the FIFO and any consumer, hides the read latency, sustains one word per cycle, and never reads an empty FIFO.

---
 rtl/fifo_rd_ctrl_pkg.sv | 21 ++
 rtl/fifo_rd_ctrl_if.sv | 25 ++
 rtl/fifo_rd_ctrl_skid_buf2.sv | 74 +++++++
 rtl/fifo_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller: controller states,
// default widths and the skid-occupancy arithmetic used by the fetch decision.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Skid occupancy after this edge: buffered words plus in-flight capture minus pop.
  function automatic logic [2:0] occ_next(input logic [1:0] occ,
                                          input logic       pend,
                                          input logic       pop);
    return {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus valid/ready output stream of the read controller.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd, out_valid, out_data
  );

endinterface

// File: rtl/fifo_rd_ctrl_skid_buf2.sv
// Two-entry register FIFO: absorbs words already fetched from the FIFO while
// the consumer stalls; head is always the oldest word.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] e0_r, e1_r, e0_n, e1_n;
  logic [1:0]            occ_r, occ_n;
  logic                  pop_s;

  assign pop_s = pop & (occ_r != 2'd0);

  // Next entry contents and occupancy for push/pop combinations.
  always_comb begin
    e0_n  = e0_r;
    e1_n  = e1_r;
    occ_n = occ_r;
    case ({push, pop_s})
      2'b10: begin
        if (occ_r == 2'd0) begin
          e0_n  = din;
          occ_n = 2'd1;
        end else if (occ_r == 2'd1) begin
          e1_n  = din;
          occ_n = 2'd2;
        end else begin
          occ_n = occ_r;
        end
      end
      2'b01: begin
        e0_n  = e1_r;
        occ_n = occ_r - 2'd1;
      end
      2'b11: begin
        if (occ_r == 2'd1) begin
          e0_n = din;
        end else begin
          e0_n = e1_r;
          e1_n = din;
        end
      end
      default: begin
        occ_n = occ_r;
      end
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_r  <= '0;
      e1_r  <= '0;
      occ_r <= 2'd0;
    end else begin
      e0_r  <= e0_n;
      e1_r  <= e1_n;
      occ_r <= occ_n;
    end
  end

  assign occ  = occ_r;
  assign head = e0_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: fetches from a one-cycle-latency FIFO into a 2-entry
// skid buffer and presents the words on a valid/ready stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  fifo_rd_ctrl_if.master       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  state_t                state_r, state_n;
  logic                  pend_r;
  logic                  busy_r;
  logic [CNT_WIDTH-1:0]  word_cnt_r;
  logic [1:0]            occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  fifo_rd_s;
  logic [2:0]            occ_after_s;

  assign valid_s     = (occ_s != 2'd0);
  assign pop_s       = valid_s & bus.out_ready;
  assign occ_after_s = occ_next(occ_s, pend_r, pop_s);

  // Fetch only when the word can still land in the skid after this edge.
  always_comb begin
    fifo_rd_s = 1'b0;
    if ((state_r == RUN) && en && !bus.fifo_empty && (occ_after_s < 3'd2)) begin
      fifo_rd_s = 1'b1;
    end else begin
      fifo_rd_s = 1'b0;
    end
  end

  // Controller next state.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          state_n = RUN;
        end else if ((occ_s != 2'd0) || pend_r) begin
          state_n = DRAIN;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (en) begin
          state_n = RUN;
        end else if (!pend_r && (occ_after_s == 3'd0)) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, in-flight flag, busy and delivered-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      pend_r     <= 1'b0;
      busy_r     <= 1'b0;
      word_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      pend_r  <= fifo_rd_s;
      busy_r  <= (state_n != IDLE);
      if (pop_s) begin
        word_cnt_r <= word_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (pend_r),
    .din   (bus.fifo_data),
    .pop   (pop_s),
    .occ   (occ_s),
    .head  (head_s)
  );

  assign bus.fifo_rd   = fifo_rd_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = head_s;
  assign busy          = busy_r;
  assign word_cnt      = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO, queue-based reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          en    = 1'b0;
  logic          busy;
  logic [CW-1:0] word_cnt;

  fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural synchronous FIFO: registered data and empty flag.
  logic         wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic         err_empty;
  logic [DW-1:0] fq[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
      bus.fifo_empty <= 1'b1;
      bus.fifo_data  <= '0;
      err_empty      <= 1'b0;
    end else begin
      if (bus.fifo_rd) begin
        if (fq.size() == 0) err_empty <= 1'b1;
        else bus.fifo_data <= fq.pop_front();
      end
      if (wr_en) fq.push_back(wr_data);
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference model: written words in order, words held downstream, read in flight.
  logic [DW-1:0] m_src[$];
  logic [DW-1:0] m_buf[$];
  logic          m_pend = 1'b0;
  int            m_mode = 0;
  logic [CW-1:0] m_cnt  = '0;
  int            cyc    = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] got[$];
  int            got_cyc[$];

  initial begin
    forever begin
      logic exp_valid, pop_m, exp_rd;
      int   occ_pre;
      logic pend_pre;
      @(negedge clk);
      #4;
      cyc++;
      if (!reset) begin
        m_mode = 0; m_buf.delete(); m_pend = 1'b0; m_cnt = '0; m_src.delete();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rd",    32'(bus.fifo_rd),   32'd0);
        chk("rst_cnt",   32'(word_cnt),      32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
      end else begin
        exp_valid = (m_buf.size() != 0);
        pop_m     = exp_valid && bus.out_ready;
        exp_rd    = (m_mode == 1) && en && !bus.fifo_empty &&
                    ((m_buf.size() + int'(m_pend) - int'(pop_m)) < 2);
        chk("valid", 32'(bus.out_valid), 32'(exp_valid));
        chk("rd",    32'(bus.fifo_rd),   32'(exp_rd));
        chk("cnt",   32'(word_cnt),      32'(m_cnt));
        chk("busy",  32'(busy),          32'(m_mode != 0));
        if (exp_valid) chk("data", 32'(bus.out_data), 32'(m_buf[0]));
        if (bus.fifo_rd) rd_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          got.push_back(bus.out_data);
          got_cyc.push_back(cyc);
        end
        occ_pre  = m_buf.size();
        pend_pre = m_pend;
        if (pop_m) begin
          void'(m_buf.pop_front());
          m_cnt = m_cnt + 16'd1;
        end
        if (m_pend) begin
          if (m_src.size() != 0) m_buf.push_back(m_src.pop_front());
          else chk("model_src", 32'd0, 32'd1);
        end
        m_pend = exp_rd;
        case (m_mode)
          0: if (en) m_mode = 1;
          1: if (!en) m_mode = ((occ_pre + int'(pend_pre)) != 0) ? 2 : 0;
          2: begin
            if (en) m_mode = 1;
            else if (!pend_pre && (occ_pre - int'(pop_m)) == 0) m_mode = 0;
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    m_src.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    got.delete();
    got_cyc.delete();
    rd_cnt = 0;
  endtask

  initial begin
    int budget;
    int mism;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);

    // Three words streamed back to back.
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    bus.out_ready = 1'b1;
    got.delete(); got_cyc.delete();
    en = 1'b1;
    cycles(10);
    chk("t1_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("t1_w0", 32'(got[0]), 32'h11);
      chk("t1_w1", 32'(got[1]), 32'h22);
      chk("t1_w2", 32'(got[2]), 32'h33);
      chk("t1_gap", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
    end
    chk("t1_cnt", 32'(word_cnt), 32'd3);
    chk("t1_err", 32'(err_empty), 32'd0);
    en = 1'b0;
    cycles(3);
    do_reset();

    // Consumer stalled: skid fills with two words, then drains gap-free.
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44); push_word(8'h55);
    bus.out_ready = 1'b0;
    rd_cnt = 0;
    en = 1'b1;
    cycles(10);
    chk("t2_rds",   32'(rd_cnt), 32'd2);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_head",  32'(bus.out_data), 32'h11);
    got.delete(); got_cyc.delete();
    bus.out_ready = 1'b1;
    cycles(10);
    chk("t2_n", 32'(got.size()), 32'd5);
    if (got.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("t2_w", 32'(got[i]), 32'(8'h11 * (i + 1)));
      chk("t2_gap", 32'(got_cyc[4] - got_cyc[0]), 32'd4);
    end
    chk("t2_cnt", 32'(word_cnt), 32'd5);
    chk("t2_err", 32'(err_empty), 32'd0);
    en = 1'b0;
    cycles(3);
    do_reset();

    // Enable dropped mid-stream: in-flight word still delivered, rest left in FIFO.
    for (int i = 0; i < 6; i++) push_word(8'(8'h61 + i));
    bus.out_ready = 1'b1;
    rd_cnt = 0;
    got.delete(); got_cyc.delete();
    en = 1'b1;
    cycles(3);
    en = 1'b0;
    cycles(6);
    chk("t3_rds", 32'(rd_cnt), 32'd2);
    chk("t3_n",   32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t3_w0", 32'(got[0]), 32'h61);
      chk("t3_w1", 32'(got[1]), 32'h62);
    end
    chk("t3_cnt",  32'(word_cnt), 32'd2);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_left", 32'(fq.size()), 32'd4);
    do_reset();

    // Empty FIFO never read; a single word fetched exactly once.
    bus.out_ready = 1'b1;
    rd_cnt = 0;
    got.delete(); got_cyc.delete();
    en = 1'b1;
    cycles(20);
    chk("t4_rds0",  32'(rd_cnt), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    push_word(8'hA5);
    cycles(8);
    chk("t4_rds1", 32'(rd_cnt), 32'd1);
    chk("t4_n",    32'(got.size()), 32'd1);
    if (got.size() == 1) chk("t4_w", 32'(got[0]), 32'hA5);
    chk("t4_cnt", 32'(word_cnt), 32'd1);
    chk("t4_err", 32'(err_empty), 32'd0);
    en = 1'b0;
    cycles(3);
    do_reset();

    // 256 words with an erratic consumer.
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      push_word(8'(i));
    end
    budget = 0;
    while (got.size() < 256 && budget < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      budget++;
    end
    chk("t5_timeout", 32'(budget < 2000), 32'd1);
    mism = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] != 8'(i)) mism++;
    chk("t5_n",   32'(got.size()), 32'd256);
    chk("t5_seq", 32'(mism), 32'd0);
    chk("t5_cnt", 32'(word_cnt), 32'd256);
    chk("t5_err", 32'(err_empty), 32'd0);
    en = 1'b0;
    cycles(3);
    do_reset();

    // Asynchronous reset between edges while words are moving.
    for (int i = 0; i < 4; i++) push_word(8'(8'h71 + i));
    bus.out_ready = 1'b1;
    en = 1'b1;
    cycles(4);
    chk("t6_pre_cnt", 32'(word_cnt != '0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rd",    32'(bus.fifo_rd),   32'd0);
    chk("t6_cnt",   32'(word_cnt),      32'd0);
    chk("t6_busy",  32'(busy),          32'd0);
    en = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(3);
    chk("t6_idle",   32'(busy), 32'd0);
    chk("t6_valid2", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
